// File: rtl/sdr_display_pkg.sv
// Shared types and helpers for the SDR magnitude display chain.
// Holds LED geometry, hold/decay FSM states and mag-to-level scaling.
package sdr_display_pkg;

   localparam int NUM_LEDS = 18;
   localparam int LEVEL_W  = 5;
   localparam int MAG_W    = 16;

   typedef enum logic [1:0] {
      TRACK = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } meter_state_e;

   // (mag * 19) >> 16 maps 0..0xFFFF onto 0..18 LEDs
   function automatic logic [LEVEL_W-1:0] mag_to_level(
      input logic [MAG_W-1:0] m
   );
      logic [20:0] prod;
      prod = 21'(m) * 21'd19;
      return prod[20:16];
   endfunction

endpackage

// File: rtl/window_peak_detector.sv
// Peak magnitude over fixed-length windows of strobed samples.
// Ports: sys_clk, reset, mag/mag_valid in; window_peak, window_done out.
module window_peak_detector
   import sdr_display_pkg::*;
#(
   parameter int unsigned WINDOW_LEN = 1024
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic [MAG_W-1:0] mag,
   input  logic             mag_valid,
   output logic [MAG_W-1:0] window_peak,
   output logic             window_done
);

   localparam int unsigned CNT_W =
      (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MAG_W-1:0] win_max_q, win_max_d;
   logic [MAG_W-1:0] window_peak_q, window_peak_d;
   logic             window_done_q, window_done_d;
   logic [MAG_W-1:0] run_max;

   always_comb begin
      run_max       = (mag > win_max_q) ? mag : win_max_q;
      cnt_d         = cnt_q;
      win_max_d     = win_max_q;
      window_peak_d = window_peak_q;
      window_done_d = 1'b0;
      if (mag_valid) begin
         if (cnt_q == LAST_IDX) begin
            // closing sample: publish and restart the window
            window_peak_d = run_max;
            window_done_d = 1'b1;
            win_max_d     = '0;
            cnt_d         = '0;
         end else begin
            win_max_d = run_max;
            cnt_d     = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnt_q         <= '0;
         win_max_q     <= '0;
         window_peak_q <= '0;
         window_done_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         win_max_q     <= win_max_d;
         window_peak_q <= window_peak_d;
         window_done_q <= window_done_d;
      end
   end

   assign window_peak = window_peak_q;
   assign window_done = window_done_q;

endmodule

// File: rtl/magnitude_peak_meter.sv
// LED bar-graph meter with peak-hold dot, timed hold and stepwise decay.
// Ports: sys_clk, reset, mag/mag_valid in; display_lines, peak_level,
// window_peak, window_done out.
module magnitude_peak_meter
   import sdr_display_pkg::*;
#(
   parameter int unsigned WINDOW_LEN   = 1024,
   parameter int unsigned HOLD_CYCLES  = 25_000_000,
   parameter int unsigned DECAY_CYCLES = 2_500_000
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic [MAG_W-1:0]    mag,
   input  logic                mag_valid,
   output logic [NUM_LEDS-1:0] display_lines,
   output logic [LEVEL_W-1:0]  peak_level,
   output logic [MAG_W-1:0]    window_peak,
   output logic                window_done
);

   localparam int unsigned HOLD_W =
      (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned DEC_W =
      (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DEC_W-1:0]  DEC_LOAD  = DEC_W'(DECAY_CYCLES - 1);

   meter_state_e        state_q, state_d;
   logic [LEVEL_W-1:0]  held_q, held_d;
   logic [LEVEL_W-1:0]  last_level_q, last_level_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
   logic [NUM_LEDS-1:0] display_lines_q, display_lines_d;
   logic [LEVEL_W-1:0]  new_level;
   logic                raise;

   window_peak_detector #(
      .WINDOW_LEN (WINDOW_LEN)
   ) u_win (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .mag         (mag),
      .mag_valid   (mag_valid),
      .window_peak (window_peak),
      .window_done (window_done)
   );

   assign new_level = mag_to_level(window_peak);
   assign raise     = window_done && (new_level >= held_q);

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      hold_cnt_d   = hold_cnt_q;
      dec_cnt_d    = dec_cnt_q;
      last_level_d = window_done ? new_level : last_level_q;
      if (raise) begin
         // a rising window wins over any timer expiry
         held_d     = new_level;
         state_d    = HOLD;
         hold_cnt_d = HOLD_LOAD;
      end else if (window_done && state_q == TRACK) begin
         state_d    = HOLD;
         hold_cnt_d = HOLD_LOAD;
      end else begin
         unique case (state_q)
            TRACK: begin
               state_d = TRACK;
            end
            HOLD: begin
               if (hold_cnt_q == '0) begin
                  state_d   = DECAY;
                  dec_cnt_d = DEC_LOAD;
               end else begin
                  hold_cnt_d = hold_cnt_q - 1'b1;
               end
            end
            DECAY: begin
               if (dec_cnt_q == '0) begin
                  // widened compare keeps held-1 from wrapping at 0
                  if ({1'b0, held_q} <= {1'b0, last_level_q} + 6'd1) begin
                     held_d  = last_level_q;
                     state_d = TRACK;
                  end else begin
                     held_d    = held_q - 1'b1;
                     dec_cnt_d = DEC_LOAD;
                  end
               end else begin
                  dec_cnt_d = dec_cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = TRACK;
            end
         endcase
      end
   end

   always_comb begin
      display_lines_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         display_lines_d[i] =
            (LEVEL_W'(i) < last_level_q) ||
            ((held_q != '0) && (LEVEL_W'(i) == held_q - 1'b1));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q         <= TRACK;
         held_q          <= '0;
         last_level_q    <= '0;
         hold_cnt_q      <= '0;
         dec_cnt_q       <= '0;
         display_lines_q <= '0;
      end else begin
         state_q         <= state_d;
         held_q          <= held_d;
         last_level_q    <= last_level_d;
         hold_cnt_q      <= hold_cnt_d;
         dec_cnt_q       <= dec_cnt_d;
         display_lines_q <= display_lines_d;
      end
   end

   assign display_lines = display_lines_q;
   assign peak_level    = held_q;

endmodule

// File: tb/tb_magnitude_peak_meter.sv
// Self-checking bench for magnitude_peak_meter with a behavioural model.
// Directed scenarios followed by randomized strobes and resets.
module tb_magnitude_peak_meter;

   localparam int WIN  = 4;
   localparam int HOLD = 8;
   localparam int DEC  = 4;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic [15:0] mag;
   logic        mag_valid;
   logic [17:0] display_lines;
   logic [4:0]  peak_level;
   logic [15:0] window_peak;
   logic        window_done;

   always #5 sys_clk = ~sys_clk;

   magnitude_peak_meter #(
      .WINDOW_LEN   (WIN),
      .HOLD_CYCLES  (HOLD),
      .DECAY_CYCLES (DEC)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .mag           (mag),
      .mag_valid     (mag_valid),
      .display_lines (display_lines),
      .peak_level    (peak_level),
      .window_peak   (window_peak),
      .window_done   (window_done)
   );

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // behavioural model: windows as sample lists, hold/decay as
   // time offsets from the last (re)start of the hold period
   int q_samp[$];
   bit m_started = 0;
   bit m_done = 0;
   int m_peak = 0;
   int m_last = 0;
   int m_held = 0;
   int m_disp = 0;
   bit m_timed = 0;
   int anchor = 0;
   int t = 0;

   function automatic int lvl_of(input int p);
      return (p * 19) / 65536;
   endfunction

   function automatic int disp_of(input int last, input int held);
      int d;
      d = (1 << last) - 1;
      if (held > 0) d = d | (1 << (held - 1));
      return d;
   endfunction

   always @(posedge sys_clk) begin
      int lvl, nheld, e, mx;
      bit ntimed;
      int nanch;
      t++;
      if (reset) begin
         q_samp.delete();
         m_started = 1;
         m_done = 0;
         m_peak = 0;
         m_last = 0;
         m_held = 0;
         m_disp = 0;
         m_timed = 0;
         anchor = 0;
      end else begin
         m_disp = disp_of(m_last, m_held);
         lvl = m_done ? lvl_of(m_peak) : 0;
         nheld = m_held;
         ntimed = m_timed;
         nanch = anchor;
         if (m_done && lvl >= m_held) begin
            nheld = lvl;
            ntimed = 1;
            nanch = t;
         end else if (m_done && !m_timed) begin
            ntimed = 1;
            nanch = t;
         end else if (m_timed) begin
            e = t - anchor - HOLD;
            if (e > 0 && (e % DEC) == 0) begin
               if (m_held <= m_last + 1) begin
                  nheld = m_last;
                  ntimed = 0;
               end else begin
                  nheld = m_held - 1;
               end
            end
         end
         if (m_done) m_last = lvl;
         m_held = nheld;
         m_timed = ntimed;
         anchor = nanch;
         m_done = 0;
         if (mag_valid) begin
            q_samp.push_back(int'(mag));
            if (q_samp.size() == WIN) begin
               mx = 0;
               foreach (q_samp[k]) if (q_samp[k] > mx) mx = q_samp[k];
               m_peak = mx;
               m_done = 1;
               q_samp.delete();
            end
         end
      end
   end

   always @(negedge sys_clk) begin
      if (m_started) begin
         chk("window_done", 32'(window_done), 32'(m_done));
         chk("window_peak", 32'(window_peak), 32'(m_peak));
         chk("peak_level", 32'(peak_level), 32'(m_held));
         chk("display_lines", 32'(display_lines), 32'(m_disp));
         if (window_done === 1'b1) done_seen++;
      end
   end

   task automatic send(input logic [15:0] m);
      mag = m;
      mag_valid = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic idle(input int n);
      mag_valid = 1'b0;
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin
      bit found;
      int r;
      reset = 1'b1;
      mag_valid = 1'b0;
      mag = '0;
      repeat (2) @(negedge sys_clk);
      chk("rst_display", 32'(display_lines), 32'h0);
      chk("rst_peak_level", 32'(peak_level), 32'h0);
      chk("rst_window_peak", 32'(window_peak), 32'h0);
      chk("rst_window_done", 32'(window_done), 32'h0);
      reset = 1'b0;
      done_seen = 0;

      send(16'd100);
      send(16'h8000);
      send(16'd5);
      send(16'd7);
      idle(2);
      chk("t2_window_peak", 32'(window_peak), 32'h8000);
      chk("t2_done_count", 32'(done_seen), 32'd1);
      chk("t2_level", 32'(peak_level), 32'd9);
      chk("t2_display", 32'(display_lines), 32'h001FF);

      repeat (4) send(16'hFFFF);
      idle(2);
      chk("t3_level", 32'(peak_level), 32'd18);
      chk("t3_display", 32'(display_lines), 32'h3FFFF);

      repeat (6) send(16'h0000);
      chk("t4_dot17", 32'(display_lines), 32'h20000);
      repeat (122) send(16'h0000);
      chk("t4_level_end", 32'(peak_level), 32'd0);
      chk("t4_display_end", 32'(display_lines), 32'h0);

      repeat (4) send(16'hFFFF);
      found = 0;
      for (int g = 0; g < 50 && !found; g++) begin
         repeat (4) send(16'h0000);
         if (peak_level <= 5'd12) found = 1;
      end
      if (!found) chk("t5_decay_timeout", 32'(peak_level), 32'd12);
      repeat (4) send(16'hFFFF);
      repeat (2) send(16'h0000);
      chk("t5_rejump", 32'(peak_level), 32'd18);
      repeat (2) send(16'h0000);

      send(16'hFFFF);
      send(16'hFFFF);
      mag_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);
      reset = 1'b0;
      chk("t6_after_reset", 32'(peak_level), 32'd0);
      repeat (4) send(16'h1000);
      idle(2);
      chk("t6_window_peak", 32'(window_peak), 32'h1000);
      chk("t6_level", 32'(peak_level), 32'd1);
      chk("t6_display", 32'(display_lines), 32'h1);

      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         mag_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 3);
         case (r)
            0: mag = 16'($urandom_range(0, 65535));
            1: mag = 16'(65535 - $urandom_range(0, 2000));
            2: mag = 16'($urandom_range(0, 4000));
            default: mag = 16'h0000;
         endcase
         @(negedge sys_clk);
      end
      reset = 1'b0;
      idle(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
